// File: rtl/nap_scheduler.sv
// Nap timer sequencer: counts a nap down in ticks, rings, handles snoozes and ack/cancel,
// and emits registered start/stop pulses for an external alarm block.
module nap_scheduler #(
   parameter int unsigned SNOOZE_SEC = 300,
   parameter int unsigned RING_MAX   = 60,
   parameter int unsigned MAX_SNOOZE = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        tick,
   input  logic        go,
   input  logic        cancel,
   input  logic        snooze,
   input  logic        ack,
   input  logic [5:0]  nap_min,
   output logic        alarm_start,
   output logic        alarm_stop,
   output logic [11:0] remaining,
   output logic [2:0]  state_code,
   output logic [1:0]  snooze_cnt,
   output logic        done
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StNap    = 3'd1,
      StRing   = 3'd2,
      StSnooze = 3'd3,
      StDone   = 3'd4
   } state_e;

   localparam logic [11:0] SnoozeLoad = 12'(SNOOZE_SEC);
   localparam logic [7:0]  RingLimit  = 8'(RING_MAX);
   localparam logic [1:0]  SnoozeMax  = 2'(MAX_SNOOZE);

   state_e      state_q, state_d;
   logic [11:0] remaining_q, remaining_d;
   logic [1:0]  snooze_cnt_q, snooze_cnt_d;
   logic [7:0]  ring_cnt_q, ring_cnt_d;
   logic        start_q, start_d;
   logic        stop_q, stop_d;
   logic [11:0] nap_load;
   logic [7:0]  ring_next;

   assign nap_load  = 12'(nap_min) * 12'd60;
   assign ring_next = ring_cnt_q + 8'd1;

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      snooze_cnt_d = snooze_cnt_q;
      ring_cnt_d   = ring_cnt_q;
      start_d      = 1'b0;
      stop_d       = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            if (cancel) begin
               state_d     = StIdle;
               remaining_d = 12'd0;
            end else if (go && nap_min != 6'd0) begin
               state_d      = StNap;
               remaining_d  = nap_load;
               snooze_cnt_d = 2'd0;
            end
         end
         StNap, StSnooze: begin
            if (cancel) begin
               state_d     = StIdle;
               remaining_d = 12'd0;
            end else if (tick) begin
               // <=1 also guards against a zero count wrapping to 4095
               if (remaining_q <= 12'd1) begin
                  state_d     = StRing;
                  remaining_d = 12'd0;
                  ring_cnt_d  = 8'd0;
                  start_d     = 1'b1;
               end else begin
                  remaining_d = remaining_q - 12'd1;
               end
            end
         end
         StRing: begin
            if (cancel) begin
               state_d     = StIdle;
               remaining_d = 12'd0;
               stop_d      = 1'b1;
            end else if (ack) begin
               state_d = StDone;
               stop_d  = 1'b1;
            end else if (snooze && snooze_cnt_q < SnoozeMax) begin
               state_d      = StSnooze;
               remaining_d  = SnoozeLoad;
               snooze_cnt_d = snooze_cnt_q + 2'd1;
               stop_d       = 1'b1;
            end else if (tick) begin
               ring_cnt_d = ring_next;
               if (ring_next == RingLimit) begin
                  state_d = StDone;
                  stop_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d     = StIdle;
            remaining_d = 12'd0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         remaining_q  <= 12'd0;
         snooze_cnt_q <= 2'd0;
         ring_cnt_q   <= 8'd0;
         start_q      <= 1'b0;
         stop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         snooze_cnt_q <= snooze_cnt_d;
         ring_cnt_q   <= ring_cnt_d;
         start_q      <= start_d;
         stop_q       <= stop_d;
      end
   end

   assign alarm_start = start_q;
   assign alarm_stop  = stop_q;
   assign remaining   = remaining_q;
   assign state_code  = state_q;
   assign snooze_cnt  = snooze_cnt_q;
   assign done        = (state_q == StDone);

endmodule

// File: tb/tb_nap_scheduler.sv
// Directed bench for nap_scheduler; per-cycle expectations are queued when stimulus is
// driven and popped after the clock edge for comparison.
module tb_nap_scheduler;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        tick = 1'b0, go = 1'b0, cancel = 1'b0, snooze = 1'b0, ack = 1'b0;
   logic [5:0]  nap_min = 6'd0;
   logic        alarm_start, alarm_stop, done;
   logic [11:0] remaining;
   logic [2:0]  state_code;
   logic [1:0]  snooze_cnt;

   localparam logic [2:0] I = 3'd0, N = 3'd1, R = 3'd2, S = 3'd3, D = 3'd4;

   typedef struct {
      string       tag;
      logic [2:0]  st;
      logic [11:0] rem;
      logic [1:0]  cnt;
      logic        start;
      logic        stop;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   nap_scheduler #(.SNOOZE_SEC(5), .RING_MAX(60), .MAX_SNOOZE(3)) dut (
      .clock       (clock),
      .reset       (reset),
      .tick        (tick),
      .go          (go),
      .cancel      (cancel),
      .snooze      (snooze),
      .ack         (ack),
      .nap_min     (nap_min),
      .alarm_start (alarm_start),
      .alarm_stop  (alarm_stop),
      .remaining   (remaining),
      .state_code  (state_code),
      .snooze_cnt  (snooze_cnt),
      .done        (done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] want);
      n_checks++;
      assert (got === want) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, got, want);
   endtask

   task automatic step(input logic t, g, c, s, a, input logic [5:0] nm, input string tag,
                       input logic [2:0] est, input logic [11:0] erem, input logic [1:0] ecnt,
                       input logic estart, estop);
      exp_t e;
      e = '{tag: tag, st: est, rem: erem, cnt: ecnt, start: estart, stop: estop};
      sb.push_back(e);
      tick = t; go = g; cancel = c; snooze = s; ack = a; nap_min = nm;
      @(posedge clock);
      #1;
      tick = 0; go = 0; cancel = 0; snooze = 0; ack = 0;
      e = sb.pop_front();
      chk({e.tag, ".state"}, 12'(state_code), 12'(e.st));
      chk({e.tag, ".remaining"}, remaining, e.rem);
      chk({e.tag, ".snooze_cnt"}, 12'(snooze_cnt), 12'(e.cnt));
      chk({e.tag, ".alarm_start"}, 12'(alarm_start), 12'(e.start));
      chk({e.tag, ".alarm_stop"}, 12'(alarm_stop), 12'(e.stop));
      chk({e.tag, ".done"}, 12'(done), 12'(e.st == D));
   endtask

   // Ticks a NAP/SNOOZE countdown from rem0 down to rem0-n (stays in that state)
   task automatic countdown(input int n, input int rem0, input logic [2:0] st,
                            input logic [1:0] cnt, input string tag);
      for (int i = 1; i <= n; i++) step(1, 0, 0, 0, 0, 6'd0, tag, st, 12'(rem0 - i), cnt, 0, 0);
   endtask

   task automatic nap_to_ring(input string tag);
      step(0, 1, 0, 0, 0, 6'd1, {tag, "_go"}, N, 12'd60, 2'd0, 0, 0);
      countdown(59, 60, N, 2'd0, tag);
      step(1, 0, 0, 0, 0, 6'd0, {tag, "_expire"}, R, 12'd0, 2'd0, 1, 0);
   endtask

   initial begin
      #2;
      chk("reset.state", 12'(state_code), 12'(I));
      chk("reset.remaining", remaining, 12'd0);
      chk("reset.snooze_cnt", 12'(snooze_cnt), 12'd0);
      chk("reset.pulses", 12'({alarm_start, alarm_stop, done}), 12'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      step(0, 1, 0, 0, 0, 6'd0, "go_zero", I, 12'd0, 2'd0, 0, 0);
      step(0, 1, 0, 0, 0, 6'd1, "go_one", N, 12'd60, 2'd0, 0, 0);
      step(0, 0, 0, 1, 1, 6'd0, "no_tick_hold", N, 12'd60, 2'd0, 0, 0);
      countdown(9, 60, N, 2'd0, "nap1");
      step(1, 1, 0, 0, 0, 6'd5, "go_in_nap", N, 12'd50, 2'd0, 0, 0);
      countdown(49, 50, N, 2'd0, "nap1b");
      step(1, 0, 0, 0, 0, 6'd0, "expire", R, 12'd0, 2'd0, 1, 0);
      step(0, 0, 0, 0, 0, 6'd0, "ring_hold", R, 12'd0, 2'd0, 0, 0);

      for (int k = 1; k <= 3; k++) begin
         step(0, 0, 0, 1, 0, 6'd0, "snooze", S, 12'd5, 2'(k), 0, 1);
         countdown(4, 5, S, 2'(k), "snz_cd");
         step(1, 0, 0, 0, 0, 6'd0, "snz_expire", R, 12'd0, 2'(k), 1, 0);
      end
      step(0, 0, 0, 1, 0, 6'd0, "snooze4_ignored", R, 12'd0, 2'd3, 0, 0);
      for (int i = 1; i < 60; i++) step(1, 0, 0, 0, 0, 6'd0, "ring_tick", R, 12'd0, 2'd3, 0, 0);
      step(1, 0, 0, 0, 0, 6'd0, "ring_timeout", D, 12'd0, 2'd3, 0, 1);
      step(1, 0, 0, 1, 1, 6'd0, "done_ignore", D, 12'd0, 2'd3, 0, 0);

      step(0, 1, 0, 0, 0, 6'd2, "done_go2", N, 12'd120, 2'd0, 0, 0);
      countdown(119, 120, N, 2'd0, "nap2");
      step(1, 0, 1, 0, 0, 6'd0, "expire_cancel", I, 12'd0, 2'd0, 0, 0);
      step(0, 0, 0, 0, 0, 6'd0, "after_cancel", I, 12'd0, 2'd0, 0, 0);

      step(0, 1, 0, 0, 0, 6'd1, "go_b", N, 12'd60, 2'd0, 0, 0);
      countdown(59, 60, N, 2'd0, "nap_b");
      step(1, 0, 0, 1, 1, 6'd0, "expire_snz_ack", R, 12'd0, 2'd0, 1, 0);
      step(0, 0, 0, 1, 1, 6'd0, "ack_over_snooze", D, 12'd0, 2'd0, 0, 1);
      step(0, 0, 1, 0, 0, 6'd0, "done_cancel", I, 12'd0, 2'd0, 0, 0);

      nap_to_ring("c");
      step(0, 1, 1, 1, 1, 6'd3, "ring_cancel", I, 12'd0, 2'd0, 0, 1);

      nap_to_ring("d");
      #2 reset = 1'b1;
      #1;
      chk("mid_reset.state", 12'(state_code), 12'(I));
      chk("mid_reset.outs", 12'({alarm_start, alarm_stop, done, snooze_cnt}), 12'd0);
      chk("mid_reset.remaining", remaining, 12'd0);
      @(negedge clock);
      reset = 1'b0;
      step(0, 0, 0, 0, 0, 6'd0, "post_reset", I, 12'd0, 2'd0, 0, 0);
      step(0, 1, 0, 0, 0, 6'd4, "post_reset_go", N, 12'd240, 2'd0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/nap_scheduler.md
NAP_SCHEDULER -- requirements
Module: nap_scheduler

Interface
REQ-001 SHALL have parameter SNOOZE_SEC, default 300, snooze length in seconds (1..4095).
REQ-002 SHALL have parameter RING_MAX, default 60, ticks of ringing before auto-stop (1..255).
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per nap (0..3).
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 tick  in  1  one-cycle 1 Hz strobe.
REQ-007 go  in  1  start nap request.
REQ-008 cancel  in  1  abort everything.
REQ-009 snooze  in  1  snooze request while ringing.
REQ-010 ack  in  1  user awake, stop ringing.
REQ-011 nap_min  in  6  nap length in minutes, sampled on accepted go.
REQ-012 alarm_start  out  1  one-cycle pulse to the alarm block's start input.
REQ-013 alarm_stop  out  1  one-cycle pulse to the alarm block's stop input.
REQ-014 remaining  out  12  seconds left in the current NAP/SNOOZE countdown.
REQ-015 state_code  out  3  IDLE=0, NAP=1, RING=2, SNOOZE=3, DONE=4.
REQ-016 snooze_cnt  out  2  snoozes used this nap.
REQ-017 done  out  1  high while in DONE.

Function
REQ-018 Input priority each cycle SHALL be: cancel > ack > snooze > go > tick/expiry.
REQ-019 IDLE: go with nap_min!=0 SHALL load remaining=nap_min*60 (max 3780, 12-bit exact), clear snooze_cnt, and go to NAP; go with nap_min==0 SHALL be ignored.
REQ-020 NAP/SNOOZE: each tick SHALL decrement remaining by 1; a tick with remaining==1 SHALL set remaining=0 and go to RING.
REQ-021 alarm_start SHALL be high for exactly the first cycle in RING, on every RING entry; ring_cnt SHALL clear on entry.
REQ-022 RING: each tick SHALL increment the internal ring_cnt (8 bits); the tick that makes ring_cnt==RING_MAX SHALL go to DONE with an alarm_stop pulse.
REQ-023 RING: snooze with snooze_cnt<MAX_SNOOZE SHALL go to SNOOZE, load remaining=SNOOZE_SEC, increment snooze_cnt, and pulse alarm_stop; with snooze_cnt==MAX_SNOOZE, snooze SHALL be ignored.
REQ-024 RING: ack SHALL go to DONE with an alarm_stop pulse.
REQ-025 cancel in any non-IDLE state SHALL go to IDLE with remaining=0; alarm_stop SHALL pulse only if cancel occurs in RING.
REQ-026 DONE: go SHALL behave as in IDLE (REQ-019); cancel SHALL go to IDLE; other inputs SHALL be ignored.
REQ-027 go SHALL be ignored in NAP, RING and SNOOZE; snooze/ack SHALL be ignored outside RING.
REQ-028 alarm_start and alarm_stop SHALL never be high in the same cycle and SHALL be registered outputs.
REQ-029 A snooze, ack or cancel coincident with the expiry tick in NAP/SNOOZE SHALL be resolved by REQ-018; cancel wins, and snooze/ack in that cycle SHALL be ignored (not yet RING).
REQ-030 Undefined state_code encodings SHALL recover to IDLE on the next clock.

Reset
REQ-031 reset SHALL asynchronously force state IDLE, remaining=0, snooze_cnt=0, ring_cnt=0, alarm_start=0, alarm_stop=0, done=0.
REQ-032 reset mid-operation SHALL NOT generate an alarm_stop pulse; the alarm block is reset by the same reset net.
REQ-033 The first clock edge after reset deassertion SHALL evaluate inputs normally.

Verification
REQ-034 nap_min=1, go, 60 ticks -> remaining 60..1..0, RING entered, alarm_start single pulse after tick 60.
REQ-035 RING, snooze x3 (SNOOZE_SEC=5, 5 ticks each) -> snooze_cnt=3, 3 alarm_stop pulses, 4 alarm_start pulses; 4th snooze ignored.
REQ-036 RING with RING_MAX=60 and no input, 60 ticks -> DONE, done=1, one alarm_stop pulse.
REQ-037 Expiry tick and cancel in the same cycle -> IDLE, no alarm_start, no alarm_stop.
REQ-038 go with nap_min=0 in IDLE -> stays IDLE; reset asserted in RING -> IDLE immediately, all outputs 0, no pulse.
REQ-039 DONE then go with nap_min=2 -> NAP, remaining=120, snooze_cnt=0.
